// File: rtl/sync_ram_pkg.sv
// Shared types and helpers for the sync_ram_init block.
// The parity helper is only used when SYNC_RAM_PARITY_EN is defined.
package sync_ram_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    // Even parity bit: makes the total number of ones (data + bit) even.
    function automatic logic even_parity(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/sync_ram_init_if.sv
// Request/response bus of sync_ram_init.
// With SYNC_RAM_PARITY_EN defined the bus also carries par_inj / par_err.
interface sync_ram_init_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic              ready;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              init_done;
`ifdef SYNC_RAM_PARITY_EN
    logic              par_inj;
    logic              par_err;
`endif

    modport master (
`ifdef SYNC_RAM_PARITY_EN
        output par_inj,
        input  par_err,
`endif
        output req, we, addr, din,
        input  ready, dout, dout_valid, init_done
    );

    modport slave (
`ifdef SYNC_RAM_PARITY_EN
        input  par_inj,
        output par_err,
`endif
        input  req, we, addr, din,
        output ready, dout, dout_valid, init_done
    );
endinterface

// File: rtl/ram_init_ctrl.sv
// Sweep controller for sync_ram_init: owns the INIT/RUN FSM, the sweep
// counter, ready/init_done, and selects between the sweep and the user
// access on the single write port of the array.
module ram_init_ctrl
    import sync_ram_pkg::*;
#(
    parameter int                ADDR_W    = 4,
    parameter int                DEPTH     = 16,
    parameter int                MEM_W     = 8,
    parameter logic [MEM_W-1:0]  INIT_WORD = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic              in_range,
    input  logic [ADDR_W-1:0] addr,
    input  logic [MEM_W-1:0]  run_word,
    output logic              ready,
    output logic              init_done,
    output logic              accept,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [MEM_W-1:0]  wr_data
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e            state;
    logic [ADDR_W-1:0] cnt;

    // Sweep FSM: one word per edge, ready/init_done registered on the last write.
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            cnt       <= '0;
            ready     <= 1'b0;
            init_done <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (cnt == LAST_ADDR) begin
                        state     <= ST_RUN;
                        ready     <= 1'b1;
                        init_done <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    assign accept = ready & req;

    // Write-port mux: the sweep owns the port until the FSM reaches ST_RUN.
    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = addr;
        wr_data = run_word;
        if (state == ST_INIT) begin
            wr_en   = 1'b1;
            wr_addr = cnt;
            wr_data = INIT_WORD;
        end else begin
            wr_en = accept & we & in_range;
        end
    end

endmodule

// File: rtl/sync_ram_init.sv
// Single-port synchronous RAM with a reset-time init sweep, registered read
// port (one-cycle latency, dout_valid strobe) and selectable read-during-write.
// Optional macro SYNC_RAM_PARITY_EN adds a stored even-parity bit per word.
// The bus interface must be instantiated with the same DATA_W/ADDR_W.
module sync_ram_init
    import sync_ram_pkg::*;
#(
    parameter int               DATA_W   = 8,
    parameter int               ADDR_W   = 4,
    parameter int               DEPTH    = 16,
    parameter int               RDW_MODE = RDW_OLD,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    sync_ram_init_if.slave  bus
);

`ifdef SYNC_RAM_PARITY_EN
    localparam int               MEM_W     = DATA_W + 1;
    localparam logic [MEM_W-1:0] INIT_WORD = {even_parity(64'(INIT_VAL)), INIT_VAL};
`else
    localparam int               MEM_W     = DATA_W;
    localparam logic [MEM_W-1:0] INIT_WORD = INIT_VAL;
`endif

    logic [MEM_W-1:0]  mem [DEPTH];
    logic              in_range;
    logic              accept;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [MEM_W-1:0]  wr_data;
    logic [MEM_W-1:0]  run_word;
    logic [MEM_W-1:0]  resp_word;
    logic [DATA_W-1:0] dout_q;
    logic              dout_valid_q;

    assign in_range = (32'(bus.addr) < DEPTH);

`ifdef SYNC_RAM_PARITY_EN
    assign run_word = {even_parity(64'(bus.din)) ^ bus.par_inj, bus.din};
`else
    assign run_word = bus.din;
`endif

    ram_init_ctrl #(
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .MEM_W     (MEM_W),
        .INIT_WORD (INIT_WORD)
    ) u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (bus.req),
        .we        (bus.we),
        .in_range  (in_range),
        .addr      (bus.addr),
        .run_word  (run_word),
        .ready     (bus.ready),
        .init_done (bus.init_done),
        .accept    (accept),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    // Storage array write port.
    // NOTE: the array has no reset; the sweep defines its contents after reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Response word: stored word, or the word being written in write-through mode.
    always_comb begin
        resp_word = mem[bus.addr];
        if (bus.we && (RDW_MODE == RDW_NEW)) begin
            resp_word = run_word;
        end
    end

    // Registered read port: updated by every accepted access, zeros when out of range.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_valid_q <= accept;
            if (accept) begin
                dout_q <= in_range ? resp_word[DATA_W-1:0] : '0;
            end
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;

`ifdef SYNC_RAM_PARITY_EN
    logic par_err_q;

    // Parity check registered alongside dout; low whenever no response is presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= accept && in_range &&
                         (even_parity(64'(resp_word[DATA_W-1:0])) != resp_word[DATA_W]);
        end
    end

    assign bus.par_err = par_err_q;
`endif

endmodule
